// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue between the instruction bus and decode.
// Up to FETCH_WIDTH slots are pushed per cycle. Up to ISSUE_WIDTH slots are presented per cycle.
// Ports:
//   clk, resetn     clock; synchronous active-low reset (drops all entries)
//   flush           discard every entry on the next edge; beats a same-cycle push/pop
//   push_valid      thermometer slot valids of the incoming fetch group
//   push_pc         PC of slot 0; slot i gets push_pc + 4*i
//   push_inst       slot i at [i*INST_W +: INST_W]
//   push_ready      room for a full FETCH_WIDTH group (registered count only)
//   pop_valid       slot j valid when count > j
//   pop_pc/pop_inst entry head+j, read combinationally
//   pop_cnt         entries consumed by decode; clamped to count
//   count, empty    occupancy
module fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 64,
  parameter int INST_W      = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              flush,
  input  logic [FETCH_WIDTH-1:0]            push_valid,
  input  logic [ADDR_W-1:0]                 push_pc,
  input  logic [FETCH_WIDTH*INST_W-1:0]     push_inst,
  output logic                              push_ready,
  output logic [ISSUE_WIDTH-1:0]            pop_valid,
  output logic [ISSUE_WIDTH*ADDR_W-1:0]     pop_pc,
  output logic [ISSUE_WIDTH*INST_W-1:0]     pop_inst,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  pop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int N_W   = $clog2(FETCH_WIDTH+1);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             push_fire;
  logic [N_W-1:0]   push_n;
  logic [N_W-1:0]   push_eff;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] pop_eff;

  // Compare against a constant so the ready path needs no subtractor on count.
  assign push_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign empty      = (count == '0);
  assign push_fire  = push_ready & push_valid[0];

  always_comb begin
    push_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      push_n = push_n + N_W'(push_valid[i]);
    end
  end

  assign push_eff = push_fire ? push_n : '0;
  assign pop_req  = CNT_W'(pop_cnt);
  assign pop_eff  = (pop_req > count) ? count : pop_req;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(push_eff);
      count <= count + CNT_W'(push_eff) - pop_eff;
    end
  end

  // Storage has no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (push_valid[i]) begin
          mem_pc[tail + PTR_W'(i)]   <= push_pc + ADDR_W'(4 * i);
          mem_inst[tail + PTR_W'(i)] <= push_inst[i*INST_W +: INST_W];
        end
      end
    end
  end

  always_comb begin
    pop_valid = '0;
    pop_pc    = '0;
    pop_inst  = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      pop_valid[j]                 = (count > CNT_W'(j));
      pop_pc[j*ADDR_W +: ADDR_W]   = mem_pc[head + PTR_W'(j)];
      pop_inst[j*INST_W +: INST_W] = mem_inst[head + PTR_W'(j)];
    end
  end

endmodule
